lcd_text_buffer: RTL
====================

// Module: lcd_text_buffer
// PURPOSE
//  Terminal-style 2x16 character buffer feeding LCD_display's row0/row1 inputs (drop-in
//  replacement for the static gen_data source). Accepts a byte stream via valid/ready,
//  interprets control codes, keeps a cursor, and presents both rows as registered
//  128-bit vectors. Multi-cycle clear and scroll run through a small FSM.
// PARAMETERS
//  BLANK_CHAR  8'h20  code written to cleared/blanked cells
//  BAD_CHAR    8'h3F  code written in place of bytes 0x7F..0xFF
// PORTS
//  clk         in   1    system clock, all logic rising-edge
//  reset_n     in   1    asynchronous active-low reset
//  in_valid    in   1    in_data valid
//  in_ready    out  1    buffer can accept a byte this cycle
//  in_data     in   8    character or control byte
//  row0        out  128  top line, column 0 at [127:120], column 15 at [7:0]
//  row1        out  128  bottom line, same packing
//  cursor_row  out  1    current cursor row
//  cursor_col  out  4    current cursor column
//  upd         out  1    1-cycle pulse, cycle after any row content change
// BEHAVIOUR
//  Reset: row0/row1 all BLANK_CHAR, cursor (0,0), upd=0, in_ready=1, state IDLE.
//  Transfer occurs when in_valid && in_ready; in_ready = (state==IDLE).
//  States: IDLE, CLEAR, SCROLL.
//  IDLE byte decode (result visible on outputs the cycle after transfer):
//   0x20..0x7E: write to cell at cursor, col+1. At col 15: row0 -> (1,0);
//     row1 -> end-of-screen (EOS) handling.
//   0x7F..0xFF: as printable, but BAD_CHAR is written.
//   0x0D CR: col=0, no write.  0x0A LF: col=0, row0 -> row1; row1 -> EOS.
//   0x08 BS: col>0 -> col-1, write BLANK_CHAR there; col==0 -> no effect, incl. row 1.
//   0x0C FF: enter CLEAR. Other 0x00..0x1F: consumed, ignored, no upd.
//  CLEAR: 32 cycles, one cell/cycle, sweep row0 col0..15 then row1 col0..15 with
//   BLANK_CHAR (5-bit counter). Last cell -> cursor (0,0), IDLE, one upd pulse.
//   in_ready=0 throughout.
//  upd: pulses after every write/BS write and after the CLEAR/SCROLL completion.
//   Never pulses for cursor-only moves.
//  Async reset at any time (mid-CLEAR/SCROLL included) returns to reset state;
//   partially cleared content is discarded.
//  in_data ignored when not transferred; no internal FIFO.
// CONFIGURATION
//  Macro LCD_TBUF_SCROLL_EN selects EOS handling.
//  Defined:
//   - EOS -> SCROLL state for 1 cycle: row0<=row1, row1<=all BLANK_CHAR,
//     cursor (1,0), upd pulse, in_ready=0 that cycle.
//   - A printable at (1,15) is written first; the scroll follows.
//  Undefined:
//   - EOS wraps cursor to (0,0) with no content move; later text overwrites.
//   - SCROLL state is not built.
// STRUCTURE
//  Package lcd_pkg:
//   - LCD_COLS=16, LCD_ROWS=2.
//   - Control constants CH_BS/CH_LF/CH_FF/CH_CR.
//   - State enum tbuf_state_t.
//  Sub-module lcd_char_decode: combinational, byte -> {is_print, is_bad, is_cr, is_lf,
//   is_bs, is_ff}.
//  Storage: 32x8 register array, packed to row0/row1.
// TESTING
//  1 Reset, then bytes "HI" -> row0[127:112]=16'h4849, rest 8'h20, cursor (0,2),
//    2 upd pulses.
//  2 17 x 'A' from home -> row0 all 8'h41, row1[127:120]=8'h41, cursor (1,1).
//  3 Send 0x0C -> in_ready low exactly 32 cycles, all cells 8'h20, cursor (0,0),
//    single upd; in_valid held high meanwhile is not accepted.
//  4 "AB",0x08,0x08,0x08 -> row0 cells 0/1 = 8'h20, cursor (0,0), third BS no upd.
//  5 Fill 32 'x' then 'y': SCROLL_EN -> row0 all 'x', row1[127:120]='y'.
//    No SCROLL_EN -> row0[127:120]='y', row1 all 'x'.
//  6 Assert reset_n low at CLEAR cycle 10 -> next edge all rows 8'h20, in_ready=1;
//    byte 0xC8 -> row0[127:120]=8'h3F.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte-class bundle for the LCD text buffer.
package lcd_pkg;

    localparam int LCD_COLS  = 16;
    localparam int LCD_ROWS  = 2;
    localparam int LCD_CELLS = LCD_COLS * LCD_ROWS;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } tbuf_state_t;

    typedef struct packed {
        logic is_print;
        logic is_bad;
        logic is_cr;
        logic is_lf;
        logic is_bs;
        logic is_ff;
    } char_class_t;

endpackage

// File: rtl/lcd_char_decode.sv
// Combinational byte classifier: printable, out-of-range, or one of the four control codes.
module lcd_char_decode
    import lcd_pkg::*;
(
    input  logic [7:0]  in_data_i,
    output char_class_t cls_o
);

    always_comb begin
        cls_o          = '0;
        cls_o.is_print = (in_data_i >= 8'h20) && (in_data_i <= 8'h7E);
        cls_o.is_bad   = (in_data_i >= 8'h7F);
        cls_o.is_cr    = (in_data_i == CH_CR);
        cls_o.is_lf    = (in_data_i == CH_LF);
        cls_o.is_bs    = (in_data_i == CH_BS);
        cls_o.is_ff    = (in_data_i == CH_FF);
    end

endmodule

// File: rtl/lcd_text_buffer.sv
// 2x16 terminal-style character buffer with cursor, control codes and multi-cycle clear.
// Define LCD_TBUF_SCROLL_EN to scroll at end of screen instead of wrapping to home.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [127:0] row0,
    output logic [127:0] row1,
    output logic         cursor_row,
    output logic [3:0]   cursor_col,
    output logic         upd
);

    logic [7:0]  cells_q [LCD_CELLS];
    logic        row_q;
    logic [3:0]  col_q;
    logic        upd_q;
    logic [4:0]  clr_cnt_q;
    tbuf_state_t state_q;

    char_class_t cls;
    logic        xfer;
    logic        is_char;
    logic        newline;
    logic [4:0]  cur_idx;
    logic [4:0]  bs_idx;
    logic [3:0]  col_dec;

    lcd_char_decode u_decode (
        .in_data_i (in_data),
        .cls_o     (cls)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign xfer     = in_valid && in_ready;
    assign is_char  = cls.is_print || cls.is_bad;
    // Either a character landing in the last column or an explicit LF moves to the next line.
    assign newline  = (is_char && (col_q == 4'd15)) || cls.is_lf;
    assign col_dec  = col_q - 4'd1;
    assign cur_idx  = {row_q, col_q};
    assign bs_idx   = {row_q, col_dec};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LCD_CELLS; i++) cells_q[i] <= BLANK_CHAR;
            row_q     <= 1'b0;
            col_q     <= 4'd0;
            upd_q     <= 1'b0;
            clr_cnt_q <= 5'd0;
            state_q   <= ST_IDLE;
        end else begin
            upd_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        if (is_char) begin
                            cells_q[cur_idx] <= cls.is_bad ? BAD_CHAR : in_data;
                            upd_q            <= 1'b1;
                        end
                        if (newline) begin
                            col_q <= 4'd0;
                            if (!row_q) begin
                                row_q <= 1'b1;
                            end else begin
`ifdef LCD_TBUF_SCROLL_EN
                                state_q <= ST_SCROLL;
`else
                                row_q <= 1'b0;
`endif
                            end
                        end else if (is_char) begin
                            col_q <= col_q + 4'd1;
                        end else if (cls.is_cr) begin
                            col_q <= 4'd0;
                        end else if (cls.is_bs) begin
                            if (col_q != 4'd0) begin
                                col_q           <= col_dec;
                                cells_q[bs_idx] <= BLANK_CHAR;
                                upd_q           <= 1'b1;
                            end
                        end else if (cls.is_ff) begin
                            clr_cnt_q <= 5'd0;
                            state_q   <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    cells_q[clr_cnt_q] <= BLANK_CHAR;
                    clr_cnt_q          <= clr_cnt_q + 5'd1;
                    if (clr_cnt_q == 5'd31) begin
                        row_q   <= 1'b0;
                        col_q   <= 4'd0;
                        upd_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
`ifdef LCD_TBUF_SCROLL_EN
                ST_SCROLL: begin
                    for (int i = 0; i < LCD_COLS; i++) begin
                        cells_q[i]            <= cells_q[i + LCD_COLS];
                        cells_q[i + LCD_COLS] <= BLANK_CHAR;
                    end
                    row_q   <= 1'b1;
                    col_q   <= 4'd0;
                    upd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Column 0 sits in the most significant byte of each row vector.
    for (genvar c = 0; c < LCD_COLS; c++) begin : g_pack
        assign row0[127-8*c -: 8] = cells_q[c];
        assign row1[127-8*c -: 8] = cells_q[LCD_COLS + c];
    end

    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign upd        = upd_q;

endmodule
